wb_timer: RTL and testbench

- Wishbone-classic responder (target) peripheral for the bexkat1 data bus. It is driven by the mem stage's initiator port (cyc/we/sel/adr/dat) through the data bus decode.
- Provides a prescaled 32-bit up-counter, a compare register with match status, optional auto-reload, and a level interrupt output.
- Occupies 8 word slots; slots 5-7 are reserved.

---
 rtl/wb_timer_pkg.sv | 31 +++
 rtl/wb_timer_if.sv | 24 ++
 rtl/wb_timer_prescale.sv | 32 +++
 rtl/wb_timer.sv | 124 ++++++++++++
 tb/tb_wb_timer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/wb_timer_pkg.sv
// Shared definitions for the bexkat1 Wishbone timer: register map, CTRL bit
// positions, handshake states and the byte-lane merge helper.
package bexkat1_timer_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_STATUS   = 3'd1;
    localparam logic [2:0] REG_COUNT    = 3'd2;
    localparam logic [2:0] REG_COMPARE  = 3'd3;
    localparam logic [2:0] REG_PRESCALE = 3'd4;

    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;
    localparam int CTRL_IE = 2;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_e;

    // Lane i of sel covers bits [8i+7:8i], so sel[3] is the MSB byte.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/wb_timer_if.sv
// Wishbone-classic bus bundle between the data-bus decode (master) and the
// timer (slave).
interface wb_timer_if;

    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [2:0]  adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;

    modport slave (
        input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        output dat_o, ack_o
    );

    modport master (
        output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        input  dat_o, ack_o
    );

endinterface

// File: rtl/wb_timer_prescale.sv
// Prescaler: counts enabled cycles and emits a one-cycle tick every
// period+1 cycles; a restart pulse rephases the count to zero.
module timer_prescale
    import bexkat1_timer_pkg::*;
#(
    parameter int PSWIDTH = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en,
    input  logic               restart,
    input  logic [PSWIDTH-1:0] period,
    output logic               tick
);

    logic [PSWIDTH-1:0] pscnt;

    assign tick = en && (pscnt == period);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pscnt <= '0;
        end else if (restart || tick) begin
            pscnt <= '0;
        end else if (en) begin
            pscnt <= pscnt + 1'b1;
        end
    end

endmodule

// File: rtl/wb_timer.sv
// Wishbone-classic timer target: prescaled 32-bit up-counter with compare,
// match status, optional auto-reload and a level interrupt.
module wb_timer
    import bexkat1_timer_pkg::*;
#(
    parameter int          PSWIDTH     = 16,
    parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    wb_timer_if.slave  bus,
    output logic       irq_o
);

    localparam logic [0:0] ST_IDLE = S_IDLE;
    localparam logic [0:0] ST_ACK  = S_ACK;

    logic [0:0]         state;
    logic [31:0]        dat_q;
    logic [2:0]         ctrl;
    logic               pending;
    logic [31:0]        count;
    logic [31:0]        compare;
    logic [PSWIDTH-1:0] prescale;

    logic               tick;
    logic               accept;
    logic               wr;
    logic               rd;
    logic               wr_ctrl, wr_status, wr_count, wr_compare, wr_prescale;
    logic               match;
    logic               set_pending;
    logic               clr_pending;
    logic [31:0]        count_tick;
    logic [31:0]        rdata;
    logic [PSWIDTH-1:0] prescale_nx;

    // A request is only taken in IDLE, so a strobe held through ACK is ignored.
    assign accept = (state == ST_IDLE) && bus.cyc_i && bus.stb_i;
    assign wr     = accept && bus.we_i;
    assign rd     = accept && !bus.we_i;

    assign wr_ctrl     = wr && (bus.adr_i == REG_CTRL);
    assign wr_status   = wr && (bus.adr_i == REG_STATUS);
    assign wr_count    = wr && (bus.adr_i == REG_COUNT);
    assign wr_compare  = wr && (bus.adr_i == REG_COMPARE);
    assign wr_prescale = wr && (bus.adr_i == REG_PRESCALE);

    assign match       = (count == compare);
    assign set_pending = tick && match;
    assign clr_pending = wr_status && bus.sel_i[0] && bus.dat_i[0];

    timer_prescale #(.PSWIDTH(PSWIDTH)) u_prescale (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en      (ctrl[CTRL_EN]),
        .restart (wr_prescale && (bus.sel_i != 4'b0000)),
        .period  (prescale),
        .tick    (tick)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        count_tick = count;
        if (tick) begin
            count_tick = (match && ctrl[CTRL_AR]) ? 32'd0 : count + 32'd1;
        end
    end

    always_comb begin
        prescale_nx = prescale;
        for (int i = 0; i < PSWIDTH; i++) begin
            if (bus.sel_i[i/8]) prescale_nx[i] = bus.dat_i[i];
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.adr_i)
            REG_CTRL:     rdata = {29'd0, ctrl};
            REG_STATUS:   rdata = {31'd0, pending};
            REG_COUNT:    rdata = count;
            REG_COMPARE:  rdata = compare;
            REG_PRESCALE: rdata = 32'(prescale);
            default:      rdata = '0;
        endcase
    end

    // Handshake and read data: one-cycle ack, dat_o valid only while acked.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
            dat_q <= '0;
        end else begin
            state <= accept ? ST_ACK : ST_IDLE;
            dat_q <= rd ? rdata : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ctrl     <= '0;
            pending  <= 1'b0;
            count    <= '0;
            compare  <= COMPARE_RST;
            prescale <= '0;
        end else begin
            if (wr_ctrl && bus.sel_i[0]) ctrl <= bus.dat_i[2:0];
            // A new match on the clearing edge keeps pending set.
            if (set_pending)      pending <= 1'b1;
            else if (clr_pending) pending <= 1'b0;
            count <= wr_count ? byte_merge(count_tick, bus.dat_i, bus.sel_i)
                              : count_tick;
            if (wr_compare)  compare  <= byte_merge(compare, bus.dat_i, bus.sel_i);
            if (wr_prescale) prescale <= prescale_nx;
        end
    end

    assign bus.ack_o = (state == ST_ACK);
    assign bus.dat_o = dat_q;
    assign irq_o     = pending && ctrl[CTRL_IE];

endmodule

// File: tb/tb_wb_timer.sv
// Scoreboard bench for wb_timer: expected read data is queued at request time
// and compared by a monitor whenever the DUT acks.
module tb_wb_timer;
    import bexkat1_timer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic irq;

    always #5 clk = ~clk;

    wb_timer_if bus ();

    wb_timer #(.PSWIDTH(16), .COMPARE_RST(32'hFFFF_FFFF)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus),
        .irq_o (irq)
    );

    typedef struct {
        logic        rd;
        logic [31:0] d;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Every ack must match a queued transfer; reads also compare data.
    always @(negedge clk) begin
        if (bus.ack_o === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_ack", 32'(bus.ack_o), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.rd) check("rd_data", bus.dat_o, e.d);
            end
        end
    end

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic xfer(input logic we, input logic [2:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [31:0] want, output logic irq_ack);
        exp_t e;
        e.rd = !we;
        e.d  = want;
        sb.push_back(e);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we;
        bus.adr_i = adr;  bus.dat_i = dat;  bus.sel_i = sel;
        @(posedge clk); #1;
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
        check("ack_hi", 32'(bus.ack_o), 32'd1);
        irq_ack = irq;
        @(posedge clk); #1;
        check("ack_lo", 32'(bus.ack_o), 32'd0);
    endtask

    task automatic wr(input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic ia;
        xfer(1'b1, adr, dat, sel, 32'd0, ia);
    endtask

    task automatic rd(input logic [2:0] adr, input logic [31:0] want);
        logic ia;
        xfer(1'b0, adr, 32'd0, 4'hF, want, ia);
    endtask

    task automatic rd_reset_map();
        logic [31:0] rv [8];
        rv = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 8; i++) rd(3'(i), rv[i]);
    endtask

    initial begin
        logic ia;
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
        bus.sel_i = 4'h0; bus.adr_i = 3'd0; bus.dat_i = 32'd0;
        cyc_wait(3);
        check("rst_ack", 32'(bus.ack_o), 32'd0);
        check("rst_dat", bus.dat_o, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rst = 1'b1;
        cyc_wait(1);

        rd_reset_map();

        // Match and interrupt with PRESCALE = 0.
        wr(REG_COMPARE, 32'd5, 4'hF);
        wr(REG_PRESCALE, 32'd0, 4'hF);
        wr(REG_CTRL, 32'h5, 4'hF);
        for (int k = 2; k <= 6; k++) begin
            cyc_wait(1);
            check("irq_rise", 32'(irq), 32'(k == 6));
        end
        rd(REG_COUNT, 32'd6);
        rd(REG_COUNT, 32'd8);
        rd(REG_STATUS, 32'd1);
        xfer(1'b1, REG_STATUS, 32'd1, 4'hF, 32'd0, ia);
        check("irq_clr", 32'(ia), 32'd0);
        check("irq_after", 32'(irq), 32'd0);

        // Auto-reload with COMPARE = 3, PRESCALE = 2: count = floor(t/3) mod 4.
        wr(REG_CTRL, 32'd0, 4'hF);
        wr(REG_STATUS, 32'd1, 4'hF);
        wr(REG_COUNT, 32'd0, 4'hF);
        wr(REG_COMPARE, 32'd3, 4'hF);
        wr(REG_PRESCALE, 32'd2, 4'hF);
        wr(REG_CTRL, 32'h7, 4'hF);
        for (int r = 2; r <= 24; r += 2) begin
            xfer(1'b0, REG_COUNT, 32'd0, 4'hF, 32'(((r - 1) / 3) % 4), ia);
            check("ar_irq", 32'(ia), 32'(r + 1 >= 12));
        end

        // Wrap FFFFFFFF -> 0 with no match flag.
        wr(REG_CTRL, 32'd0, 4'hF);
        wr(REG_STATUS, 32'd1, 4'hF);
        wr(REG_COMPARE, 32'd10, 4'hF);
        wr(REG_PRESCALE, 32'd0, 4'hF);
        wr(REG_COUNT, 32'd0, 4'hF);
        wr(REG_CTRL, 32'h5, 4'hF);
        wr(REG_COUNT, 32'hFFFF_FFFE, 4'hF);
        rd(REG_COUNT, 32'hFFFF_FFFF);
        wr(REG_COUNT, 32'hFFFF_FFFE, 4'hF);
        cyc_wait(1);
        rd(REG_COUNT, 32'h0000_0000);
        wr(REG_COUNT, 32'hFFFF_FFFE, 4'hF);
        cyc_wait(2);
        rd(REG_COUNT, 32'h0000_0001);
        rd(REG_STATUS, 32'd0);
        check("wrap_irq", 32'(irq), 32'd0);

        // Byte lanes, tick-edge partial write, sel = 0, field widths.
        wr(REG_CTRL, 32'd0, 4'hF);
        wr(REG_COUNT, 32'h1122_3344, 4'hF);
        wr(REG_COUNT, 32'hAABB_CCDD, 4'b0101);
        rd(REG_COUNT, 32'h11BB_33DD);
        wr(REG_CTRL, 32'h1, 4'hF);
        wr(REG_COUNT, 32'h0000_0055, 4'b0001);
        rd(REG_COUNT, 32'h11BB_3356);
        wr(REG_CTRL, 32'd0, 4'hF);
        wr(REG_COUNT, 32'hCAFE_F00D, 4'hF);
        wr(REG_COUNT, 32'd0, 4'b0000);
        rd(REG_COUNT, 32'hCAFE_F00D);
        wr(REG_CTRL, 32'hFFFF_FFFA, 4'hF);
        rd(REG_CTRL, 32'h2);
        wr(REG_PRESCALE, 32'hFFFF_FFFF, 4'hF);
        rd(REG_PRESCALE, 32'h0000_FFFF);
        wr(3'd5, 32'h1234_5678, 4'hF);
        rd(3'd5, 32'd0);

        // Strobe held through ACK: acks at N+1 and N+3 only.
        begin
            exp_t e;
            e.rd = 1'b1;
            e.d  = 32'd10;
            sb.push_back(e);
            sb.push_back(e);
        end
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0;
        bus.adr_i = REG_COMPARE; bus.sel_i = 4'hF;
        cyc_wait(1); check("hold_n1", 32'(bus.ack_o), 32'd1);
        cyc_wait(1); check("hold_n2", 32'(bus.ack_o), 32'd0);
        cyc_wait(1); check("hold_n3", 32'(bus.ack_o), 32'd1);
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
        cyc_wait(1); check("hold_n4", 32'(bus.ack_o), 32'd0);

        // Reset on the request edge drops the transfer.
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
        bus.adr_i = REG_COUNT; bus.dat_i = 32'hDEAD_BEEF; bus.sel_i = 4'hF;
        rst = 1'b0;
        cyc_wait(1);
        check("rst_drop", 32'(bus.ack_o), 32'd0);
        rst = 1'b1;
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
        cyc_wait(1);
        check("rst_drop2", 32'(bus.ack_o), 32'd0);
        check("rst_irq2", 32'(irq), 32'd0);
        rd_reset_map();

        cyc_wait(2);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
